// File: rtl/pll_lock_detect.sv
// pll_lock_detect: measures the freq_in / freq_synced periods in Clock cycles and declares
// lock after LOCK_COUNT consecutive in-tolerance compares. Define PLL_LOCK_SYNC_EN to add 2-flop input synchronizers.
`ifndef N_BIT
`define N_BIT 8
`endif

module pll_lock_detect #(
    parameter int unsigned W          = `N_BIT,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         freq_in,
    input  logic         freq_synced,
    output logic         locked,
    output logic         lost_lock,
    output logic [W-1:0] period_ref,
    output logic [W-1:0] period_out,
    output logic         period_valid
);
    localparam logic [W-1:0] PMAX   = '1;
    localparam logic [7:0]   LOCK_N = 8'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    logic [1:0] sig_in;
    assign sig_in = {freq_synced, freq_in};

    // Channel 0 measures freq_in, channel 1 measures freq_synced.
    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic         sig_s;
        logic         prev_q, prev_d, edge_q, edge_d, vld_q, vld_d;
        logic [W-1:0] cnt_q, cnt_d, per_q, per_d;

`ifdef PLL_LOCK_SYNC_EN
        logic [1:0] sync_q, sync_d;
        assign sync_d = {sync_q[0], sig_in[g]};
        assign sig_s  = sync_q[1];

        always_ff @(posedge Clock or negedge nReset) begin
            if (!nReset) sync_q <= '0;
            else         sync_q <= sync_d;
        end
`else
        assign sig_s = sig_in[g];
`endif

        always_comb begin
            prev_d = sig_s;
            edge_d = sig_s & ~prev_q;
            cnt_d  = cnt_q;
            per_d  = per_q;
            vld_d  = vld_q;
            if (edge_q) begin
                per_d = cnt_q;
                cnt_d = W'(1);
                vld_d = 1'b1;
            end else begin
                if (cnt_q != PMAX) cnt_d = cnt_q + W'(1);
                // A saturated counter means the channel has stalled.
                if (cnt_d == PMAX) vld_d = 1'b0;
            end
        end

        always_ff @(posedge Clock or negedge nReset) begin
            if (!nReset) begin
                prev_q <= 1'b0;
                edge_q <= 1'b0;
                vld_q  <= 1'b0;
                cnt_q  <= '0;
                per_q  <= '0;
            end else begin
                prev_q <= prev_d;
                edge_q <= edge_d;
                vld_q  <= vld_d;
                cnt_q  <= cnt_d;
                per_q  <= per_d;
            end
        end
    end

    logic [W-1:0] per_ref, per_out;
    logic         pv;
    assign per_ref = g_chan[0].per_q;
    assign per_out = g_chan[1].per_q;
    assign pv      = g_chan[0].vld_q & g_chan[1].vld_q;

    logic [W:0] diff;
    logic       match;
    always_comb begin
        if (per_ref >= per_out) diff = {1'b0, per_ref} - {1'b0, per_out};
        else                    diff = {1'b0, per_out} - {1'b0, per_ref};
        match = (diff <= (W+1)'(TOL)) && (per_ref != PMAX) && (per_out != PMAX);
    end

    state_t     state_q, state_d;
    logic [7:0] mcnt_q, mcnt_d;
    logic       cmp_q, cmp_d;
    logic       locked_q, locked_d, lost_lock_q, lost_lock_d;

    // cmp_q trails e_ref by one cycle so a reference capture on e_ref is compared.
    always_comb begin
        cmp_d       = g_chan[0].edge_q;
        state_d     = state_q;
        mcnt_d      = mcnt_q;
        locked_d    = locked_q;
        lost_lock_d = 1'b0;
        if (!pv) begin
            state_d     = IDLE;
            mcnt_d      = '0;
            locked_d    = 1'b0;
            lost_lock_d = (state_q == LOCKED);
        end else begin
            unique case (state_q)
                IDLE, ACQUIRE: begin
                    state_d = ACQUIRE;
                    if (cmp_q) begin
                        if (match) begin
                            mcnt_d = mcnt_q + 8'd1;
                            if (mcnt_d >= LOCK_N) begin
                                mcnt_d   = LOCK_N;
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            mcnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (cmp_q && !match) begin
                        state_d     = ACQUIRE;
                        mcnt_d      = '0;
                        locked_d    = 1'b0;
                        lost_lock_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            mcnt_q      <= '0;
            cmp_q       <= 1'b0;
            locked_q    <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            cmp_q       <= cmp_d;
            locked_q    <= locked_d;
            lost_lock_q <= lost_lock_d;
        end
    end

    assign locked       = locked_q;
    assign lost_lock    = lost_lock_q;
    assign period_ref   = per_ref;
    assign period_out   = per_out;
    assign period_valid = pv;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Scoreboarded bench for pll_lock_detect: a timestamp-based reference model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_pll_lock_detect;
    localparam int W          = 8;
    localparam int TOL        = 1;
    localparam int LOCK_COUNT = 4;
    localparam int PMAX       = (1 << W) - 1;
`ifdef PLL_LOCK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         Clock = 1'b0;
    logic         nReset = 1'b0;
    logic         freq_in = 1'b0;
    logic         freq_synced = 1'b0;
    logic         locked, lost_lock, period_valid;
    logic [W-1:0] period_ref, period_out;

    always #5 Clock = ~Clock;

    pll_lock_detect #(.W(W), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT)) dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .freq_in      (freq_in),
        .freq_synced  (freq_synced),
        .locked       (locked),
        .lost_lock    (lost_lock),
        .period_ref   (period_ref),
        .period_out   (period_out),
        .period_valid (period_valid)
    );

    typedef struct packed {
        logic         locked;
        logic         lost;
        logic [W-1:0] pref;
        logic [W-1:0] pout;
        logic         pv;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: edge timestamps per channel, periods as timestamp differences.
    int n;
    int last_s[2];
    int prev_s[2];
    bit has[2];
    bit in_prev[2];
    int pend0[$];
    int pend1[$];
    bit m_locked;
    int m_cnt;
    bit pv_prev;
    bit cmp_prev;
    int per_prev[2];

    // Stimulus generators: period 0 means the input is held low.
    int gp[2];
    int gph[2];

    task automatic model_reset();
        n = 0;
        for (int c = 0; c < 2; c++) begin
            last_s[c] = 0; prev_s[c] = 0; has[c] = 1'b0; in_prev[c] = 1'b0; per_prev[c] = 0;
        end
        pend0.delete();
        pend1.delete();
        m_locked = 1'b0; m_cnt = 0; pv_prev = 1'b0; cmp_prev = 1'b0;
    endtask

    task automatic model_edge(input bit fi, input bit fo, output obs_t e);
        int  per[2];
        bit  vld[2];
        bit  cap_ref;
        bit  ok;
        bit  lost;
        int  d;
        n++;
        if (fi && !in_prev[0]) pend0.push_back(n + LAT);
        if (fo && !in_prev[1]) pend1.push_back(n + LAT);
        in_prev[0] = fi;
        in_prev[1] = fo;
        cap_ref = 1'b0;
        if (pend0.size() != 0 && pend0[0] + 1 == n) begin
            prev_s[0] = last_s[0]; last_s[0] = pend0.pop_front(); has[0] = 1'b1; cap_ref = 1'b1;
        end
        if (pend1.size() != 0 && pend1[0] + 1 == n) begin
            prev_s[1] = last_s[1]; last_s[1] = pend1.pop_front(); has[1] = 1'b1;
        end
        for (int c = 0; c < 2; c++) begin
            per[c] = has[c] ? ((last_s[c] - prev_s[c] > PMAX) ? PMAX : last_s[c] - prev_s[c]) : 0;
            vld[c] = has[c] && (n - last_s[c] < PMAX);
        end
        lost = 1'b0;
        if (!pv_prev) begin
            lost = m_locked; m_locked = 1'b0; m_cnt = 0;
        end else if (cmp_prev) begin
            d  = per_prev[0] - per_prev[1];
            if (d < 0) d = -d;
            ok = (d <= TOL) && (per_prev[0] != PMAX) && (per_prev[1] != PMAX);
            if (ok) begin
                if (!m_locked) begin
                    m_cnt++;
                    if (m_cnt >= LOCK_COUNT) m_locked = 1'b1;
                end
            end else begin
                lost = m_locked; m_locked = 1'b0; m_cnt = 0;
            end
        end
        e.locked = m_locked;
        e.lost   = lost;
        e.pref   = W'(per[0]);
        e.pout   = W'(per[1]);
        e.pv     = vld[0] && vld[1];
        pv_prev  = e.pv;
        cmp_prev = cap_ref;
        per_prev[0] = per[0];
        per_prev[1] = per[1];
    endtask

    task automatic set_gen(input int c, input int p, input int ph);
        gp[c]  = p;
        gph[c] = ph;
    endtask

    task automatic step(input bit rst_n_next);
        obs_t e;
        bit   v[2];
        e = '0;
        @(posedge Clock);
        #1;
        if (nReset) model_edge(freq_in, freq_synced, e);
        for (int c = 0; c < 2; c++) begin
            if (gp[c] == 0) begin
                v[c] = 1'b0;
            end else begin
                gph[c] = (gph[c] + 1) % gp[c];
                v[c]   = (gph[c] < gp[c] / 2);
            end
        end
        freq_in     = v[0];
        freq_synced = v[1];
        nReset      = rst_n_next;
        if (!rst_n_next) begin
            model_reset();
            e = '0;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one expected observation per cycle, sampled mid-cycle.
    initial begin
        obs_t want, got;
        forever begin
            @(negedge Clock);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = {locked, lost_lock, period_ref, period_out, period_valid};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL cycle_trace t=%0t got locked=%0b lost=%0b pref=%0d pout=%0d pv=%0b expected locked=%0b lost=%0b pref=%0d pout=%0d pv=%0b",
                             $time, got.locked, got.lost, got.pref, got.pout, got.pv,
                             want.locked, want.lost, want.pref, want.pout, want.pv);
                end
            end
        end
    end

    initial begin
        int p0, p1, len;
        model_reset();
        // Reset held with toggling inputs, then released with static inputs.
        set_gen(0, 4, 3);
        set_gen(1, 6, 5);
        repeat (10) step(1'b0);
        set_gen(0, 0, 0);
        set_gen(1, 0, 0);
        repeat (30) step(1'b1);
        // Acquire: 20 vs 21.
        set_gen(0, 20, 19);
        set_gen(1, 21, 20);
        repeat (250) step(1'b1);
        // Out of tolerance: 20 vs 23.
        gp[1] = 23;
        repeat (250) step(1'b1);
        // Relock, loss of lock at 30, relock at 20.
        gp[1] = 20;
        repeat (200) step(1'b1);
        gp[1] = 30;
        repeat (120) step(1'b1);
        gp[1] = 20;
        repeat (200) step(1'b1);
        // Timeout: output stalls past saturation, then restarts.
        gp[1] = 0;
        repeat (300) step(1'b1);
        set_gen(1, 20, 19);
        repeat (250) step(1'b1);
        // Mid-operation reset while locked.
        repeat (3) step(1'b0);
        repeat (250) step(1'b1);
        // Simultaneous edges on both inputs.
        set_gen(0, 16, 15);
        set_gen(1, 16, 15);
        repeat (200) step(1'b1);
        // Randomized segments around the tolerance boundary.
        for (int k = 0; k < 12; k++) begin
            p0  = $urandom_range(40, 8);
            p1  = p0 + $urandom_range(4, 0) - 2;
            len = $urandom_range(300, 100);
            gp[0] = p0;
            gp[1] = ($urandom_range(7, 0) == 0) ? 0 : p1;
            if ($urandom_range(5, 0) == 0) step(1'b0);
            repeat (len) step(1'b1);
        end
        @(negedge Clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
